// File: rtl/seq_mult_hs.sv
// seq_mult_hs - sequential shift-and-add multiplier with valid/ready handshakes.
//
// Takes one operand pair at a time and iterates one multiplier bit per cycle.
// The full 2W-bit product is held until the consumer accepts it.
// Signed operation uses sign-magnitude: the magnitudes are multiplied unsigned,
// and the result is negated when the operand signs differ.
//
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN
//   When defined, the iteration stops as soon as the remaining multiplier bits
//   are at most 1. The result is unchanged, but latency becomes msb(B)+1.
//   When undefined, every operation takes exactly W cycles.
//
// Parameters:
//   W             operand width (W >= 2)
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   in_valid      operand pair and mode are valid
//   in_ready      block can accept operands (IDLE only)
//   signed_mode   1 = two's-complement operands, 0 = unsigned; sampled on accept
//   multiplicand  operand A
//   multiplier    operand B
//   out_valid     product holds a final result
//   out_ready     consumer accepts the result
//   product       registered 2W-bit result
//   busy          high in RUN or DONE
module seq_mult_hs #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           signed_mode,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic [CW-1:0]  count;
  logic           neg;

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] sum;
  logic           last;
  logic           accept;

  assign accept = in_valid && (state == IDLE);

  // Magnitudes: -2^(W-1) negates to itself, which reads correctly as unsigned.
  always_comb begin
    mag_a = multiplicand;
    mag_b = multiplier;
    if (signed_mode && multiplicand[W-1]) mag_a = -multiplicand;
    if (signed_mode && multiplier[W-1])   mag_b = -multiplier;
  end

  always_comb begin
    sum  = product + (b[0] ? a : '0);
    last = (count == CW'(W - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
    // Nothing left to add beyond the current bit, so finish now.
    if (b[W-1:1] == '0) last = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a       <= {{W{1'b0}}, mag_a};
            b       <= mag_b;
            neg     <= signed_mode & (multiplicand[W-1] ^ multiplier[W-1]);
            product <= '0;
            count   <= '0;
          end
        end
        RUN: begin
          a     <= a << 1;
          b     <= b >> 1;
          count <= count + 1'b1;
          // Sign is applied only once, on the final partial sum.
          if (last) product <= neg ? -sum : sum;
          else      product <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs - directed self-checking bench for seq_mult_hs (W = 8).
// Expected latencies depend on whether SEQ_MULT_EARLY_TERM_EN is defined.
module tb_seq_mult_hs;

  localparam int W = 8;
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           signed_mode;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int fails  = 0;

  seq_mult_hs #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand pair, then counts edges from acceptance to out_valid.
  // Returns cycles = -1 when the result never arrives.
  task automatic run_op(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                        input logic sm, output logic [2*W-1:0] prod,
                        output int cycles);
    in_valid     = 1'b1;
    multiplicand = a_in;
    multiplier   = b_in;
    signed_mode  = sm;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    multiplicand = 8'hA5;
    multiplier   = 8'h5A;
    signed_mode  = ~sm;
    cycles = -1;
    prod   = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cycles = i;
        prod   = product;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    signed_mode = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (product !== 16'h0000) begin
      fails++; $display("[TB] FAIL reset_product: got %h expected 0000", product);
    end
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      fails++; $display("[TB] FAIL reset_flags: got ov/busy/ir=%b expected 001", {out_valid, busy, in_ready});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    logic [2*W-1:0] p;
    int n;
    run_op(8'hFF, 8'hFF, 1'b0, p, n);
    checks++;
    if (p !== 16'hFE01) begin
      fails++; $display("[TB] FAIL u_255x255: got %h expected fe01", p);
    end
    checks++;
    if (n !== 8) begin
      fails++; $display("[TB] FAIL u_255x255_latency: got %0d expected 8", n);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL done_in_ready: got %b expected 0", in_ready);
    end
    // out_ready already high, so DONE lasts exactly one cycle.
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++; $display("[TB] FAIL done_one_cycle: got ov/ir/busy=%b expected 010", {out_valid, in_ready, busy});
    end
    run_op(8'h80, 8'h02, 1'b0, p, n);
    checks++;
    if (p !== 16'h0100) begin
      fails++; $display("[TB] FAIL u_0x80x2: got %h expected 0100", p);
    end
    checks++;
    if (n !== (EARLY ? 2 : 8)) begin
      fails++; $display("[TB] FAIL u_0x80x2_latency: got %0d expected %0d", n, EARLY ? 2 : 8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    logic [2*W-1:0] p;
    int n;
    run_op(8'h80, 8'h80, 1'b1, p, n);
    checks++;
    if (p !== 16'h4000) begin
      fails++; $display("[TB] FAIL s_m128xm128: got %h expected 4000", p);
    end
    checks++;
    if (n !== 8) begin
      fails++; $display("[TB] FAIL s_m128xm128_latency: got %0d expected 8", n);
    end
    @(posedge clk); #1;
    run_op(8'hFD, 8'h05, 1'b1, p, n);
    checks++;
    if (p !== 16'hFFF1) begin
      fails++; $display("[TB] FAIL s_m3x5: got %h expected fff1", p);
    end
    checks++;
    if (n !== (EARLY ? 3 : 8)) begin
      fails++; $display("[TB] FAIL s_m3x5_latency: got %0d expected %0d", n, EARLY ? 3 : 8);
    end
    @(posedge clk); #1;
    run_op(8'h80, 8'h02, 1'b1, p, n);
    checks++;
    if (p !== 16'hFF00) begin
      fails++; $display("[TB] FAIL s_0x80x2: got %h expected ff00", p);
    end
    @(posedge clk); #1;
    run_op(8'h05, 8'hFD, 1'b1, p, n);
    checks++;
    if (p !== 16'hFFF1) begin
      fails++; $display("[TB] FAIL s_5xm3: got %h expected fff1", p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_early_term;
    logic [2*W-1:0] p;
    int n;
    run_op(8'd15, 8'd0, 1'b0, p, n);
    checks++;
    if (p !== 16'd0) begin
      fails++; $display("[TB] FAIL et_b0: got %h expected 0000", p);
    end
    checks++;
    if (n !== (EARLY ? 1 : 8)) begin
      fails++; $display("[TB] FAIL et_b0_latency: got %0d expected %0d", n, EARLY ? 1 : 8);
    end
    @(posedge clk); #1;
    run_op(8'd15, 8'd5, 1'b0, p, n);
    checks++;
    if (p !== 16'd75) begin
      fails++; $display("[TB] FAIL et_b5: got %h expected 004b", p);
    end
    checks++;
    if (n !== (EARLY ? 3 : 8)) begin
      fails++; $display("[TB] FAIL et_b5_latency: got %0d expected %0d", n, EARLY ? 3 : 8);
    end
    @(posedge clk); #1;
    run_op(8'd15, 8'h80, 1'b0, p, n);
    checks++;
    if (p !== 16'h0780) begin
      fails++; $display("[TB] FAIL et_b80: got %h expected 0780", p);
    end
    checks++;
    if (n !== 8) begin
      fails++; $display("[TB] FAIL et_b80_latency: got %0d expected 8", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [2*W-1:0] p;
    int n;
    int bad;
    out_ready = 1'b0;
    run_op(8'd15, 8'd5, 1'b0, p, n);
    checks++;
    if (p !== 16'd75) begin
      fails++; $display("[TB] FAIL bp_result: got %h expected 004b", p);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid     = i[0] ? 1'b0 : 1'b1;
      multiplicand = 8'd3 + 8'(i);
      multiplier   = 8'd3;
      @(posedge clk); #1;
      if (product !== 16'd75 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      fails++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0 (product %h)", bad, product);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++; $display("[TB] FAIL bp_release: got ir/ov/busy=%b expected 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] p;
    int n;
    run_op(8'd9, 8'd9, 1'b0, p, n);
    checks++;
    if (p !== 16'd81) begin
      fails++; $display("[TB] FAIL b2b_first: got %h expected 0051", p);
    end
    // New operands presented during DONE; accepted only one edge after Ed.
    in_valid     = 1'b1;
    multiplicand = 8'd12;
    multiplier   = 8'd11;
    signed_mode  = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      fails++; $display("[TB] FAIL b2b_bubble: got ir/busy=%b expected 10", {in_ready, busy});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      fails++; $display("[TB] FAIL b2b_accept: got ir/busy=%b expected 01", {in_ready, busy});
    end
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = i; break; end
    end
    checks++;
    if (n < 0 || product !== 16'd132) begin
      fails++; $display("[TB] FAIL b2b_second: got %h after %0d cycles expected 0084", product, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    logic [2*W-1:0] p;
    int n;
    in_valid     = 1'b1;
    multiplicand = 8'd200;
    multiplier   = 8'd201;
    signed_mode  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (product !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL mid_run_reset: got product %h ov %b busy %b ir %b expected 0000 0 0 1",
                        product, out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'd7, 8'd6, 1'b0, p, n);
    checks++;
    if (p !== 16'd42) begin
      fails++; $display("[TB] FAIL after_reset_7x6: got %h expected 002a", p);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_early_term;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_mult_hs.md
# seq_mult_hs

Parametrised sequential shift-and-add multiplier with a valid/ready handshake on both input and output, plus per-operation signed or unsigned mode. It is the next-generation datapath multiplier for the arithmetic unit. It takes one operand pair at a time, iterates one multiplier bit per cycle, and holds the full-width product until the consumer accepts it. Signed operation uses sign-magnitude: the magnitudes are multiplied unsigned and the result is negated when the operand signs differ.

## Interface

Parameters:
- `W`, default 8: operand width; legal range W >= 2.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand pair and mode are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled on acceptance.
- `multiplicand`  in  W  operand A.
- `multiplier`  in  W  operand B.
- `out_valid`  out  1  `product` holds a final result.
- `out_ready`  in  1  consumer accepts the result.
- `product`  out  2W  registered result.
- `busy`  out  1  high in RUN or DONE.

## Operation

- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `product` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1. Internal A, B, iteration count and neg flag are all cleared to 0.
- IDLE:
  - On `in_valid && in_ready` at an edge, load A = |multiplicand| zero-extended to 2W bits, and B = |multiplier| (W bits).
  - Magnitudes apply only when `signed_mode` = 1; otherwise raw values are loaded.
  - Also at that edge: neg = `signed_mode` & (sign of multiplicand XOR sign of multiplier), `product` = 0, count = 0. Go to RUN.
  - |−2^(W−1)| = 2^(W−1) and fits in W unsigned bits. No overflow is possible.
- RUN, each cycle:
  - sum = `product` + (B[0] ? A : 0), computed with 2W-bit wrap; no true overflow is possible.
  - A <<= 1, B >>= 1, count++.
  - last = (count == W−1), or the early-termination condition (see Configuration).
  - If last: `product` <= neg ? −sum : sum (2W-bit two's complement), then go to DONE. Otherwise `product` <= sum.
- DONE:
  - `out_valid` = 1 and `product` is held stable.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored. Operands and mode may change freely after acceptance.
- Reset mid-operation: state and all outputs return to reset values immediately, and the in-flight result is discarded.

## Timing

- Acceptance edge E0. RUN occupies N cycles, and `out_valid` rises just after edge E0+N.
- Fixed N = W when the macro is absent.
- `product` changes every RUN cycle and is valid only while `out_valid` = 1.
- Output handshake edge Ed: IDLE and `in_ready` = 1 in the next cycle. The earliest next acceptance is edge Ed+1, so there is no zero-bubble back-to-back operation.
- `in_ready` and `out_valid` are never high simultaneously.
- `out_ready` held high before DONE: the handshake completes on the first DONE edge, so DONE lasts exactly 1 cycle.

## Configuration

- `SEQ_MULT_EARLY_TERM_EN` defined:
  - last also asserts when B[W−1:1] == 0, i.e. the remaining multiplier bits are at most 1.
  - N = (index of the most-significant set bit of the loaded B) + 1, with N = 1 for B = 0. Maximum N = W.
  - The result is identical to the fixed mode.
- Macro absent: fixed N = W for every operand pair, and the early-termination logic is not present.

## Test plan

- Unsigned, W=8: 255 × 255 -> `product` = 0xFE01. Macro absent: `out_valid` rises exactly 8 cycles after the acceptance edge.
- Signed, W=8:
  - −128 × −128 -> 0x4000.
  - −3 × 5 -> 0xFFF1.
  - 0x80 × 0x02 signed -> 0xFF00; the same operands unsigned -> 0x0100.
- Early termination (macro defined), W=8:
  - multiplier 0 -> `product` 0 after N=1.
  - multiplier 5 -> 15 × 5 = 75 after N=3.
  - multiplier 0x80 -> N=8.
  - Macro absent: all three take N=8.
- Backpressure: hold `out_ready` = 0 for 5 DONE cycles while pulsing `in_valid` with new operands.
  - Required: `product` stable, `in_ready` = 0, new operands ignored.
  - Raise `out_ready`: IDLE the next cycle and `in_ready` = 1.
- Reset mid-RUN: assert `rst` asynchronously in the 3rd RUN cycle.
  - Required: `product` = 0, `out_valid` = 0, `busy` = 0 immediately.
  - After release, 7 × 6 unsigned -> 42.
